// File: rtl/bcd_disp_ctrl.sv
// Binary-to-BCD front-end for the multiplexed display: double-dabble conversion,
// saturation, leading-zero blanking and an atomic commit to the display registers.
module bcd_disp_ctrl #(
    parameter int DIS_NUM = 4,
    parameter int BIN_W   = 14
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [BIN_W-1:0]       i_bin,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_blank_lz,
    output logic [DIS_NUM*4-1:0]   o_bcd_data,
    output logic [DIS_NUM-1:0]     o_digit_en,
    output logic                   o_ovf,
    output logic                   o_update
);

    localparam int BCD_W = DIS_NUM * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]      MAX_VAL = pow10(DIS_NUM) - 64'd1;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIS_NUM{4'h9}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SR_W-1:0]    sreg;
    logic [SR_W-1:0]    sreg_adj;
    logic [SR_W-1:0]    sreg_shifted;
    logic [CNT_W-1:0]   cnt;
    logic               blank_q;
    logic               sat_q;
    logic               bin_sat;
    logic               last_iter;
    logic [BCD_W-1:0]   bcd_part;
    logic [DIS_NUM-1:0] en_next;
    logic               lead_zero;

    assign o_ready   = (state == IDLE) && i_rst;
    assign bin_sat   = {{(64-BIN_W){1'b0}}, i_bin} > MAX_VAL;
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));
    assign bcd_part  = sreg[SR_W-1 -: BCD_W];

    // One double-dabble step: correct every BCD nibble of 5 or more, then shift.
    always_comb begin
        sreg_adj = sreg;
        for (int i = 0; i < DIS_NUM; i++) begin
            if (sreg[BIN_W + 4*i +: 4] >= 4'd5) begin
                sreg_adj[BIN_W + 4*i +: 4] = sreg[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        sreg_shifted = {sreg_adj[SR_W-2:0], 1'b0};
    end

    always_comb begin
        en_next   = '1;
        lead_zero = 1'b1;
        for (int k = DIS_NUM - 1; k >= 1; k--) begin
            lead_zero = lead_zero && (bcd_part[4*k +: 4] == 4'd0);
            if (blank_q && !sat_q && lead_zero) begin
                en_next[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_next = bin_sat ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers change freely; the display-facing outputs only move in COMMIT.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sreg       <= '0;
            cnt        <= '0;
            blank_q    <= 1'b0;
            sat_q      <= 1'b0;
            o_bcd_data <= '0;
            o_digit_en <= '1;
            o_ovf      <= 1'b0;
            o_update   <= 1'b0;
        end else begin
            o_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        blank_q <= i_blank_lz;
                        cnt     <= '0;
                        if (bin_sat) begin
                            sreg  <= {ALL_NINES, {BIN_W{1'b0}}};
                            sat_q <= 1'b1;
                        end else begin
                            sreg  <= {{BCD_W{1'b0}}, i_bin};
                            sat_q <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    sreg <= sreg_shifted;
                    cnt  <= cnt + 1'b1;
                end
                COMMIT: begin
                    o_bcd_data <= bcd_part;
                    o_digit_en <= en_next;
                    o_ovf      <= sat_q;
                    o_update   <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Directed self-checking bench for bcd_disp_ctrl (DIS_NUM=4, BIN_W=14).
module tb_bcd_disp_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [13:0] i_bin;
    logic        i_valid;
    logic        o_ready;
    logic        i_blank_lz;
    logic [15:0] o_bcd_data;
    logic [3:0]  o_digit_en;
    logic        o_ovf;
    logic        o_update;

    int checks = 0;
    int errors = 0;

    bcd_disp_ctrl #(.DIS_NUM(4), .BIN_W(14)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_bin      (i_bin),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_blank_lz (i_blank_lz),
        .o_bcd_data (o_bcd_data),
        .o_digit_en (o_digit_en),
        .o_ovf      (o_ovf),
        .o_update   (o_update)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Called at a negedge; returns just after the transfer edge E0.
    task automatic transfer(input logic [13:0] bin, input logic blank);
        i_bin      = bin;
        i_blank_lz = blank;
        i_valid    = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    // Counts edges after E0 until o_update is seen at a negedge; -1 on timeout.
    task automatic wait_update(output int edges, output int busy);
        edges = 0;
        busy  = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (o_update) return;
            if (!o_ready) busy++;
            @(posedge i_clk);
            edges++;
        end
        edges = -1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_valid = 1'b0; i_bin = '0; i_blank_lz = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_bcd_data !== 16'h0000) begin errors++; $display("[TB] FAIL rst_bcd got %h exp 0000", o_bcd_data); end
        checks++; if (o_digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL rst_en got %b exp 1111", o_digit_en); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got %b exp 0", o_ovf); end
        checks++; if (o_update !== 1'b0) begin errors++; $display("[TB] FAIL rst_update got %b exp 0", o_update); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready_low got %b exp 0", o_ready); end
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready_high got %b exp 1", o_ready); end
        checks++; if (o_update !== 1'b0) begin errors++; $display("[TB] FAIL idle_update got %b exp 0", o_update); end
    endtask

    task automatic test_basic();
        int edges, busy;
        transfer(14'd1234, 1'b0);
        wait_update(edges, busy);
        checks++; if (edges != 15) begin errors++; $display("[TB] FAIL basic_latency got %0d exp 15", edges); end
        checks++; if (busy != 15) begin errors++; $display("[TB] FAIL basic_busy got %0d exp 15", busy); end
        checks++; if (o_bcd_data !== 16'h1234) begin errors++; $display("[TB] FAIL basic_bcd got %h exp 1234", o_bcd_data); end
        checks++; if (o_digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL basic_en got %b exp 1111", o_digit_en); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL basic_ovf got %b exp 0", o_ovf); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready_at_update got %b exp 1", o_ready); end
        @(negedge i_clk);
        checks++; if (o_update !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse_width got %b exp 0", o_update); end
        checks++; if (o_bcd_data !== 16'h1234) begin errors++; $display("[TB] FAIL basic_hold got %h exp 1234", o_bcd_data); end
    endtask

    task automatic test_blanking();
        logic [13:0] vin  [3] = '{14'd42, 14'd0, 14'd305};
        logic [15:0] vbcd [3] = '{16'h0042, 16'h0000, 16'h0305};
        logic [3:0]  ven  [3] = '{4'b0011, 4'b0001, 4'b0111};
        int edges, busy;
        for (int i = 0; i < 3; i++) begin
            transfer(vin[i], 1'b1);
            wait_update(edges, busy);
            checks++; if (edges != 15) begin errors++; $display("[TB] FAIL blank_latency[%0d] got %0d exp 15", i, edges); end
            checks++; if (o_bcd_data !== vbcd[i]) begin errors++; $display("[TB] FAIL blank_bcd[%0d] got %h exp %h", i, o_bcd_data, vbcd[i]); end
            checks++; if (o_digit_en !== ven[i]) begin errors++; $display("[TB] FAIL blank_en[%0d] got %b exp %b", i, o_digit_en, ven[i]); end
        end
    endtask

    task automatic test_boundary();
        logic [13:0] vin   [3] = '{14'd9999, 14'd12000, 14'd10000};
        logic        vblk  [3] = '{1'b1, 1'b0, 1'b1};
        logic        vovf  [3] = '{1'b0, 1'b1, 1'b1};
        int          vedge [3] = '{15, 1, 1};
        int edges, busy;
        for (int i = 0; i < 3; i++) begin
            transfer(vin[i], vblk[i]);
            wait_update(edges, busy);
            // Saturated values commit on E1, the edge right after transfer.
            checks++; if (edges != vedge[i]) begin errors++; $display("[TB] FAIL bound_latency[%0d] got %0d exp %0d", i, edges, vedge[i]); end
            checks++; if (o_bcd_data !== 16'h9999) begin errors++; $display("[TB] FAIL bound_bcd[%0d] got %h exp 9999", i, o_bcd_data); end
            checks++; if (o_ovf !== vovf[i]) begin errors++; $display("[TB] FAIL bound_ovf[%0d] got %b exp %b", i, o_ovf, vovf[i]); end
            checks++; if (o_digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL bound_en[%0d] got %b exp 1111", i, o_digit_en); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int edge_at [2] = '{-1, -1};
        logic [15:0] val_at [2] = '{16'hxxxx, 16'hxxxx};
        i_bin = 14'd7; i_blank_lz = 1'b0; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_bin = 14'd8;
        for (int e = 1; e <= 45; e++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (e == 20) i_bin = 14'd9;
            if (o_update) begin
                if (pulses < 2) begin
                    edge_at[pulses] = e;
                    val_at[pulses]  = o_bcd_data;
                end
                pulses++;
                if (pulses == 2) i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL b2b_pulses got %0d exp 2", pulses); end
        checks++; if (edge_at[0] != 15) begin errors++; $display("[TB] FAIL b2b_first_edge got %0d exp 15", edge_at[0]); end
        checks++; if (val_at[0] !== 16'h0007) begin errors++; $display("[TB] FAIL b2b_first_val got %h exp 0007", val_at[0]); end
        checks++; if (edge_at[1] != 31) begin errors++; $display("[TB] FAIL b2b_second_edge got %0d exp 31", edge_at[1]); end
        checks++; if (val_at[1] !== 16'h0008) begin errors++; $display("[TB] FAIL b2b_second_val got %h exp 0008", val_at[1]); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf got %b exp 0", o_ovf); end
    endtask

    task automatic test_reset_abort();
        int edges, busy;
        int pulses = 0;
        transfer(14'd555, 1'b0);
        wait_update(edges, busy);
        checks++; if (o_bcd_data !== 16'h0555) begin errors++; $display("[TB] FAIL abort_pre_bcd got %h exp 0555", o_bcd_data); end
        transfer(14'd1234, 1'b0);
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_bcd_data !== 16'h0555) begin errors++; $display("[TB] FAIL abort_hold got %h exp 0555", o_bcd_data); end
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_bcd_data !== 16'h0000) begin errors++; $display("[TB] FAIL abort_bcd got %h exp 0000", o_bcd_data); end
        checks++; if (o_digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL abort_en got %b exp 1111", o_digit_en); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("[TB] FAIL abort_ovf got %b exp 0", o_ovf); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready_low got %b exp 0", o_ready); end
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready_high got %b exp 1", o_ready); end
        for (int n = 0; n < 20; n++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_update) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL abort_no_update got %0d exp 0", pulses); end
        checks++; if (o_bcd_data !== 16'h0000) begin errors++; $display("[TB] FAIL abort_still_reset got %h exp 0000", o_bcd_data); end
        transfer(14'd88, 1'b0);
        wait_update(edges, busy);
        checks++; if (edges != 15) begin errors++; $display("[TB] FAIL post_latency got %0d exp 15", edges); end
        checks++; if (o_bcd_data !== 16'h0088) begin errors++; $display("[TB] FAIL post_bcd got %h exp 0088", o_bcd_data); end
        checks++; if (o_digit_en !== 4'b1111) begin errors++; $display("[TB] FAIL post_en got %b exp 1111", o_digit_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blanking();
        test_boundary();
        test_back_to_back();
        repeat (3) @(negedge i_clk);
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
